// File: rtl/misc_pipe.sv
// Two-stage elastic mul10/div10/mod10/add/xor unit with a tag carried beside each op; optional out_ovf under MISC_OVF_FLAG_EN.
// Latency: 2 cycles from acceptance to out_valid; 1 op/cycle throughput.
// Backpressure: out_ready low holds the S2 result stable and in_ready drops once S1 is also occupied; flush blocks input.
module misc_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
`ifdef MISC_OVF_FLAG_EN
    ,
    output logic             out_ovf
`endif
);

    // Reciprocal multiplier: floor(2^(WIDTH+3)/10)+1, exact division for every WIDTH-bit operand.
    localparam logic [WIDTH+3:0] DIV_SCALE = {1'b1, {(WIDTH + 3){1'b0}}};
    localparam logic [WIDTH+3:0] TEN       = (WIDTH + 4)'(10);
    localparam logic [WIDTH+3:0] ONE       = (WIDTH + 4)'(1);
    localparam logic [WIDTH-1:0] M         = WIDTH'((DIV_SCALE / TEN) + ONE);

    logic                 s1_v;
    logic                 s2_v;
    logic [2:0]           s1_op;
    logic [TAG_W-1:0]     s1_tag;
    logic [WIDTH-1:0]     s1_a;
    logic [WIDTH-1:0]     s1_b;
    logic [2*WIDTH-1:0]   s1_prod;

    logic                 s1_adv;
    logic                 s1_load;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     mul_res;
    logic [WIDTH-1:0]     add_res;
    logic [WIDTH-1:0]     res_nxt;

    assign s1_adv    = !s2_v || out_ready;
    assign s1_load   = !s1_v || s1_adv;
    assign in_ready  = rstn && !flush && s1_load;
    assign out_valid = s2_v;

`ifdef MISC_OVF_FLAG_EN
    logic [WIDTH+3:0] mul_w;
    logic [WIDTH:0]   add_w;
    logic             ovf_nxt;

    assign mul_w   = ({4'b0, s1_a} << 3) + ({4'b0, s1_a} << 1);
    assign add_w   = {1'b0, s1_a} + {1'b0, s1_b};
    assign mul_res = mul_w[WIDTH-1:0];
    assign add_res = add_w[WIDTH-1:0];
    assign ovf_nxt = (s1_op == 3'd0) ? |mul_w[WIDTH+3:WIDTH] :
                     (s1_op == 3'd3) ? add_w[WIDTH] : 1'b0;
`else
    assign mul_res = (s1_a << 3) + (s1_a << 1);
    assign add_res = s1_a + s1_b;
`endif

    assign quot = WIDTH'(s1_prod >> (WIDTH + 3));

    always_comb begin
        res_nxt = s1_a ^ s1_b;
        case (s1_op)
            3'd0:    res_nxt = mul_res;
            3'd1:    res_nxt = quot;
            3'd2:    res_nxt = s1_a - ((quot << 3) + (quot << 1));
            3'd3:    res_nxt = add_res;
            default: res_nxt = s1_a ^ s1_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            s1_op      <= '0;
            s1_tag     <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_prod    <= '0;
            out_result <= '0;
            out_tag    <= '0;
`ifdef MISC_OVF_FLAG_EN
            out_ovf    <= 1'b0;
`endif
        end else if (flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    out_result <= res_nxt;
                    out_tag    <= s1_tag;
`ifdef MISC_OVF_FLAG_EN
                    out_ovf    <= ovf_nxt;
`endif
                end
            end
            // S1 refills in the same cycle S2 drains, so no bubble at full rate.
            if (s1_load) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_op   <= in_op;
                    s1_tag  <= in_tag;
                    s1_a    <= in_a;
                    s1_b    <= in_b;
                    s1_prod <= {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, M};
                end
            end
        end
    end

endmodule

// File: tb/tb_misc_pipe.sv
// Bench for misc_pipe: directed vector table, multi-cycle corner sequences, and a random run against a queue model.
module tb_misc_pipe;
    localparam int W  = 32;
    localparam int TW = 5;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_a, in_b, out_result;
    logic [TW-1:0] in_tag, out_tag;

    logic          h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_flush;
    logic [2:0]    h_in_op;
    logic [15:0]   h_in_a, h_in_b, h_out_result;
    logic [TW-1:0] h_in_tag, h_out_tag;
`ifdef MISC_OVF_FLAG_EN
    logic          out_ovf, h_out_ovf;
`endif

    misc_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
`ifdef MISC_OVF_FLAG_EN
        , .out_ovf(out_ovf)
`endif
    );

    misc_pipe #(.WIDTH(16), .TAG_W(TW)) dut16 (
        .clk(clk), .rstn(rstn), .flush(h_flush),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .in_op(h_in_op),
        .in_a(h_in_a), .in_b(h_in_b), .in_tag(h_in_tag),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out_result(h_out_result), .out_tag(h_out_tag)
`ifdef MISC_OVF_FLAG_EN
        , .out_ovf(h_out_ovf)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the op definitions, returns {ovf, result}.
    function automatic logic [W:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] w;
        logic [W:0]  r;
        case (op)
            3'd0: begin w = 64'(a) * 64'd10; r = {(w >= 64'h1_0000_0000), w[W-1:0]}; end
            3'd1: r = {1'b0, a / 32'd10};
            3'd2: r = {1'b0, a % 32'd10};
            3'd3: begin w = 64'(a) + 64'(b); r = {w[W], w[W-1:0]}; end
            default: r = {1'b0, a ^ b};
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 3))
            0: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            1: return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [2:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        logic [W-1:0]  res;
        logic          ovf;
        string         name;
    } vec_t;

    typedef struct {
        logic [W-1:0]  res;
        logic          ovf;
        logic [TW-1:0] tag;
    } exp_t;

    vec_t vecs[12];
    exp_t q[$];
    int   tags_seen[$];

    initial begin
        int idx;
        int sent, cyc;
        logic stall_prev;
        logic [W-1:0] stall_res;
        logic [TW-1:0] stall_tag;
        logic [W:0] r;
        exp_t e;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'h0, 5'd7,  32'h1999_9999, 1'b0, "div10_max"};
        vecs[1]  = '{3'd1, 32'd9,         32'h0, 5'd1,  32'd0,         1'b0, "div10_9"};
        vecs[2]  = '{3'd1, 32'd100,       32'h0, 5'd2,  32'd10,        1'b0, "div10_100"};
        vecs[3]  = '{3'd2, 32'd123,       32'h0, 5'd3,  32'd3,         1'b0, "mod10_123"};
        vecs[4]  = '{3'd2, 32'hFFFF_FFFF, 32'h0, 5'd4,  32'd5,         1'b0, "mod10_max"};
        vecs[5]  = '{3'd2, 32'd0,         32'h0, 5'd5,  32'd0,         1'b0, "mod10_0"};
        vecs[6]  = '{3'd0, 32'h2000_0000, 32'h0, 5'd6,  32'h4000_0000, 1'b1, "mul10_wrap"};
        vecs[7]  = '{3'd0, 32'd5,         32'h0, 5'd8,  32'd50,        1'b0, "mul10_5"};
        vecs[8]  = '{3'd3, 32'hFFFF_FFFF, 32'd2, 5'd9,  32'd1,         1'b1, "add_carry"};
        vecs[9]  = '{3'd3, 32'd10,        32'd20, 5'd10, 32'd30,       1'b0, "add_small"};
        vecs[10] = '{3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd11, 32'hFF00_FF00, 1'b0, "xor_op4"};
        vecs[11] = '{3'd7, 32'h1234_5678, 32'hFFFF_FFFF, 5'd31, 32'hEDCB_A987, 1'b0, "xor_op7"};

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        h_flush = 1'b0; h_in_valid = 1'b0; h_out_ready = 1'b1;
        h_in_op = '0; h_in_a = '0; h_in_b = '0; h_in_tag = '0;
        tick(); tick();
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_result", out_result, 0);
        chk("reset_out_tag", out_tag, 0);
        rstn = 1'b1;
        tick();

        foreach (vecs[i]) begin
            in_valid = 1'b1; in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b; in_tag = vecs[i].tag;
            #1;
            chk({vecs[i].name, "_in_ready"}, in_ready, 1);
            tick();
            in_valid = 1'b0;
            chk({vecs[i].name, "_lat1_valid"}, out_valid, 0);
            tick();
            chk({vecs[i].name, "_valid"}, out_valid, 1);
            chk({vecs[i].name, "_result"}, out_result, vecs[i].res);
            chk({vecs[i].name, "_tag"}, out_tag, vecs[i].tag);
`ifdef MISC_OVF_FLAG_EN
            chk({vecs[i].name, "_ovf"}, out_ovf, vecs[i].ovf);
`endif
        end
        tick();

        // Backpressure: four tagged adds with the consumer stalled for five cycles.
        out_ready = 1'b0; idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4); in_op = 3'd3; in_a = 32'((idx + 1) * 100); in_b = 32'd1; in_tag = 5'(idx + 1);
            #1;
            if (in_valid && in_ready) idx++;
            tick();
        end
        #1;
        chk("bp_accepts", idx, 2);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_held_valid", out_valid, 1);
        chk("bp_held_result", out_result, 101);
        chk("bp_held_tag", out_tag, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (idx < 4); in_op = 3'd3; in_a = 32'((idx + 1) * 100); in_b = 32'd1; in_tag = 5'(idx + 1);
            #1;
            if (out_valid && out_ready) begin
                tags_seen.push_back(int'(out_tag));
                chk("bp_drain_result", out_result, 64'(out_tag) * 100 + 1);
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_out_count", tags_seen.size(), 4);
        foreach (tags_seen[i]) chk("bp_order", tags_seen[i], i + 1);

        // Flush with both stages full and a competing input.
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd0; in_a = 32'd3; in_tag = 5'd10; tick();
        in_tag = 5'd11; tick();
        in_tag = 5'd12; flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        chk("flush_pre_valid", out_valid, 1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        out_ready = 1'b1;
        tick();
        chk("flush_no_leftover", out_valid, 0);
        in_valid = 1'b1; in_op = 3'd3; in_a = 32'd7; in_b = 32'd8; in_tag = 5'd13;
        tick();
        in_valid = 1'b0;
        chk("flush_resume_lat1", out_valid, 0);
        tick();
        chk("flush_resume_valid", out_valid, 1);
        chk("flush_resume_result", out_result, 15);
        chk("flush_resume_tag", out_tag, 13);
        tick();

        // Reset pulse mid-stream.
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd5; in_a = 32'h55; in_b = 32'hAA; in_tag = 5'd20; tick();
        in_tag = 5'd21; tick();
        rstn = 1'b0; in_tag = 5'd22;
        #1;
        chk("rst_in_ready", in_ready, 0);
        tick();
        rstn = 1'b1; in_valid = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_no_stale", out_valid, 0);
        end

        // WIDTH=16 instance.
        h_in_valid = 1'b1; h_in_op = 3'd1; h_in_a = 16'hFFFF; h_in_tag = 5'd3;
        tick();
        h_in_op = 3'd2; h_in_tag = 5'd4;
        tick();
        h_in_valid = 1'b0;
        chk("w16_div_valid", h_out_valid, 1);
        chk("w16_div_result", h_out_result, 16'h1999);
        chk("w16_div_tag", h_out_tag, 3);
        tick();
        chk("w16_mod_result", h_out_result, 5);
        chk("w16_mod_tag", h_out_tag, 4);
        tick();

        // Random traffic against the queue model, with occasional flushes.
        sent = 0; cyc = 0; stall_prev = 1'b0; stall_res = '0; stall_tag = '0;
        while ((sent < 10000 || q.size() > 0) && cyc < 60000) begin
            in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
            in_op     = 3'($urandom_range(0, 7));
            in_a      = rand_operand();
            in_b      = rand_operand();
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) == 0);
            #1;
            if (stall_prev) begin
                chk("rnd_stall_valid", out_valid, 1);
                chk("rnd_stall_result", out_result, stall_res);
                chk("rnd_stall_tag", out_tag, stall_tag);
            end
            if (flush) chk("rnd_flush_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_result", out_result, e.res);
                    chk("rnd_tag", out_tag, e.tag);
`ifdef MISC_OVF_FLAG_EN
                    chk("rnd_ovf", out_ovf, e.ovf);
`endif
                end
            end
            if (in_valid && in_ready) begin
                r = ref_op(in_op, in_a, in_b);
                q.push_back('{r[W-1:0], r[W], in_tag});
                sent++;
            end
            if (flush) q.delete();
            stall_prev = out_valid && !out_ready && !flush;
            stall_res  = out_result;
            stall_tag  = out_tag;
            tick();
            cyc++;
        end
        flush = 1'b0; in_valid = 1'b0;
        chk("rnd_completed_in_budget", (cyc < 60000), 1);
        chk("rnd_all_sent", sent, 10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
